// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: state encodings, the 32-bit cycle-count
// type, and a helper that clamps a phase length to at least one cycle.
package wash_pkg;

   typedef logic [31:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RINSE = 3'd4,
      ST_SPIN  = 3'd5,
      ST_DONE  = 3'd6,
      ST_PAUSE = 3'd7
   } state_t;

   // A zero-length phase would never see a terminal count; run it for one cycle.
   function automatic cnt_t min_one(input cnt_t v);
      return (v == '0) ? cnt_t'(1) : v;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 32-bit down-counter holding the cycles left in the current phase.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset, clears the count
//   load      - load load_val on the next edge (wins over en)
//   load_val  - value to load
//   en        - decrement on the next edge; holds at zero
//   count     - current count
//   last      - count equals one (terminal cycle of the phase)
module phase_timer
   import wash_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  cnt_t load_val,
   input  logic en,
   output cnt_t count,
   output logic last
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - cnt_t'(1);
      end
   end

   assign last = (count == cnt_t'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine cycle sequencer: FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE,
// each phase timed by phase_timer, with abort handling and door interlock.
//
// Build option: WASH_DOOR_PAUSE_EN - when defined, opening the door during
// FILL..SPIN pauses the cycle (timer frozen) and closing it resumes. When not
// defined, an open door during FILL..SPIN behaves exactly like abort.
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   start        - one-cycle request to begin a cycle (IDLE only, door closed)
//   abort        - level request to end the cycle early
//   door_closed  - door sensor, 1 = closed
//   phase        - current state encoding
//   busy         - any state other than IDLE
//   done         - single-cycle pulse in DONE
//   valve_on, motor_on, motor_fast, pump_on - actuator drives
//   door_lock    - door locked during FILL..SPIN
//   remaining    - cycles left in the current phase, including this one
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start with the door closed
// FILL     | water inlet valve open
// WASH     | drum turning slowly
// DRAIN    | pump running; after an abort this leads straight to IDLE
// RINSE    | valve open and drum turning
// SPIN     | drum fast with pump running
// DONE     | one-cycle completion pulse
// PAUSE    | door opened mid-cycle; timer frozen, phase saved
module wash_sequencer
   import wash_pkg::*;
#(
   parameter cnt_t FILL_CYC  = 32'd1000,
   parameter cnt_t WASH_CYC  = 32'd1000000,
   parameter cnt_t DRAIN_CYC = 32'd1000,
   parameter cnt_t RINSE_CYC = 32'd500000,
   parameter cnt_t SPIN_CYC  = 32'd500000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        door_closed,
   output logic [2:0]  phase,
   output logic        busy,
   output logic        done,
   output logic        valve_on,
   output logic        motor_on,
   output logic        motor_fast,
   output logic        pump_on,
   output logic        door_lock,
   output logic [31:0] remaining
);

   localparam cnt_t FILL_LEN  = min_one(FILL_CYC);
   localparam cnt_t WASH_LEN  = min_one(WASH_CYC);
   localparam cnt_t DRAIN_LEN = min_one(DRAIN_CYC);
   localparam cnt_t RINSE_LEN = min_one(RINSE_CYC);
   localparam cnt_t SPIN_LEN  = min_one(SPIN_CYC);

   state_t state, state_nxt;
   logic   abort_drain, abort_drain_nxt;
   logic   tmr_load, tmr_en, tmr_last;
   cnt_t   tmr_load_val, tmr_count;
   logic   abort_req, pause_req;

`ifdef WASH_DOOR_PAUSE_EN
   state_t saved, saved_nxt;
   assign abort_req = abort;
   assign pause_req = !door_closed;
`else
   assign abort_req = abort | !door_closed;
   assign pause_req = 1'b0;
`endif

   function automatic cnt_t phase_len(input state_t s);
      case (s)
         ST_FILL:  return FILL_LEN;
         ST_WASH:  return WASH_LEN;
         ST_DRAIN: return DRAIN_LEN;
         ST_RINSE: return RINSE_LEN;
         ST_SPIN:  return SPIN_LEN;
         default:  return '0;
      endcase
   endfunction

   function automatic state_t seq_next(input state_t s);
      case (s)
         ST_FILL:  return ST_WASH;
         ST_WASH:  return ST_DRAIN;
         ST_DRAIN: return ST_RINSE;
         ST_RINSE: return ST_SPIN;
         ST_SPIN:  return ST_DONE;
         default:  return ST_IDLE;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         abort_drain <= 1'b0;
`ifdef WASH_DOOR_PAUSE_EN
         saved       <= ST_IDLE;
`endif
      end else begin
         state       <= state_nxt;
         abort_drain <= abort_drain_nxt;
`ifdef WASH_DOOR_PAUSE_EN
         saved       <= saved_nxt;
`endif
      end
   end

   // Entering IDLE or DONE loads zero so remaining reads 0 there.
   always_comb begin
      state_nxt       = state;
      abort_drain_nxt = abort_drain;
      tmr_load        = 1'b0;
      tmr_load_val    = '0;
      tmr_en          = 1'b0;
`ifdef WASH_DOOR_PAUSE_EN
      saved_nxt       = saved;
`endif
      case (state)
         ST_IDLE: begin
            abort_drain_nxt = 1'b0;
            if (start && door_closed) begin
               state_nxt    = ST_FILL;
               tmr_load     = 1'b1;
               tmr_load_val = FILL_LEN;
            end
         end
         ST_FILL, ST_WASH, ST_RINSE: begin
            if (abort_req) begin
               state_nxt       = ST_DRAIN;
               tmr_load        = 1'b1;
               tmr_load_val    = DRAIN_LEN;
               abort_drain_nxt = 1'b1;
            end else if (pause_req) begin
               state_nxt = ST_PAUSE;
`ifdef WASH_DOOR_PAUSE_EN
               saved_nxt = state;
`endif
            end else if (tmr_last) begin
               state_nxt    = seq_next(state);
               tmr_load     = 1'b1;
               tmr_load_val = phase_len(seq_next(state));
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (pause_req) begin
               state_nxt = ST_PAUSE;
`ifdef WASH_DOOR_PAUSE_EN
               saved_nxt = state;
`endif
            end else if (tmr_last) begin
               tmr_load = 1'b1;
               if (abort_drain) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt    = ST_RINSE;
                  tmr_load_val = RINSE_LEN;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_SPIN: begin
            if (abort_req) begin
               state_nxt = ST_IDLE;
               tmr_load  = 1'b1;
            end else if (pause_req) begin
               state_nxt = ST_PAUSE;
`ifdef WASH_DOOR_PAUSE_EN
               saved_nxt = state;
`endif
            end else if (tmr_last) begin
               state_nxt = ST_DONE;
               tmr_load  = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         ST_PAUSE: begin
`ifdef WASH_DOOR_PAUSE_EN
            if (abort) begin
               state_nxt = ST_IDLE;
               tmr_load  = 1'b1;
            end else if (door_closed) begin
               state_nxt = saved;
            end
`else
            state_nxt = ST_IDLE;
            tmr_load  = 1'b1;
`endif
         end
         default: begin
            state_nxt = ST_IDLE;
            tmr_load  = 1'b1;
         end
      endcase
   end

   phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .count    (tmr_count),
      .last     (tmr_last)
   );

   always_comb begin
      busy       = (state != ST_IDLE);
      done       = 1'b0;
      valve_on   = 1'b0;
      motor_on   = 1'b0;
      motor_fast = 1'b0;
      pump_on    = 1'b0;
      door_lock  = 1'b0;
      case (state)
         ST_FILL: begin
            valve_on  = 1'b1;
            door_lock = 1'b1;
         end
         ST_WASH: begin
            motor_on  = 1'b1;
            door_lock = 1'b1;
         end
         ST_DRAIN: begin
            pump_on   = 1'b1;
            door_lock = 1'b1;
         end
         ST_RINSE: begin
            valve_on  = 1'b1;
            motor_on  = 1'b1;
            door_lock = 1'b1;
         end
         ST_SPIN: begin
            motor_on   = 1'b1;
            motor_fast = 1'b1;
            pump_on    = 1'b1;
            door_lock  = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign phase     = state;
   assign remaining = tmr_count;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer with short phase lengths
// (FILL=3, WASH=5, DRAIN=2, RINSE=4, SPIN=3). Stimulus pushes the expected
// per-cycle observation; a monitor pops and compares on each falling edge.
module tb_wash_sequencer;
   import wash_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        door_closed = 1'b1;
   logic [2:0]  phase;
   logic        busy, done, valve_on, motor_on, motor_fast, pump_on, door_lock;
   logic [31:0] remaining;

   wash_sequencer #(
      .FILL_CYC  (32'd3),
      .WASH_CYC  (32'd5),
      .DRAIN_CYC (32'd2),
      .RINSE_CYC (32'd4),
      .SPIN_CYC  (32'd3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .door_closed (door_closed),
      .phase       (phase),
      .busy        (busy),
      .done        (done),
      .valve_on    (valve_on),
      .motor_on    (motor_on),
      .motor_fast  (motor_fast),
      .pump_on     (pump_on),
      .door_lock   (door_lock),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  ph;
      logic [31:0] rem;
      logic [6:0]  fl;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   // {busy, done, valve, motor, fast, pump, lock}
   function automatic logic [6:0] flags_of(input logic [2:0] ph);
      case (ph)
         3'd0:    return 7'b0000000;
         3'd1:    return 7'b1010001;
         3'd2:    return 7'b1001001;
         3'd3:    return 7'b1000011;
         3'd4:    return 7'b1011001;
         3'd5:    return 7'b1001111;
         3'd6:    return 7'b1100000;
         default: return 7'b1000000;
      endcase
   endfunction

   wire [6:0] act_fl = {busy, done, valve_on, motor_on, motor_fast, pump_on, door_lock};

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (phase === e.ph && remaining === e.rem && act_fl === e.fl)
            n_pass++;
         else
            $display("FAIL %s: got phase=%0d rem=%0d flags=%b, want phase=%0d rem=%0d flags=%b",
                     e.name, phase, remaining, act_fl, e.ph, e.rem, e.fl);
      end
   end

   task automatic step(input string nm, input logic s, input logic a, input logic d,
                       input logic [2:0] ph, input logic [31:0] rem);
      exp_t e;
      #1;
      start = s;
      abort = a;
      door_closed = d;
      e.name = nm;
      e.ph   = ph;
      e.rem  = rem;
      e.fl   = flags_of(ph);
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic run_phase(input string nm, input logic [2:0] ph, input int len,
                            input logic a, input logic d);
      for (int i = len; i >= 1; i--) step(nm, 1'b0, a, d, ph, i);
   endtask

   task automatic check_now(input string nm, input logic [2:0] ph, input logic [31:0] rem,
                            input logic [6:0] fl);
      n_checks++;
      if (phase === ph && remaining === rem && act_fl === fl)
         n_pass++;
      else
         $display("FAIL %s: got phase=%0d rem=%0d flags=%b, want phase=%0d rem=%0d flags=%b",
                  nm, phase, remaining, act_fl, ph, rem, fl);
   endtask

   task automatic normal_to_rinse(input string nm);
      step({nm, "_start"}, 1'b1, 1'b0, 1'b1, 3'd0, 0);
      run_phase({nm, "_fill"}, 3'd1, 3, 1'b0, 1'b1);
      run_phase({nm, "_wash"}, 3'd2, 5, 1'b0, 1'b1);
      run_phase({nm, "_drain"}, 3'd3, 2, 1'b0, 1'b1);
      run_phase({nm, "_rinse"}, 3'd4, 4, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0;
      #12;
      check_now("por", 3'd0, 0, 7'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      step("idle_after_por", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("idle_after_por", 1'b0, 1'b0, 1'b1, 3'd0, 0);

      // full cycle; start during WASH ignored, abort in DONE/IDLE ignored
      step("n_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      run_phase("n_fill", 3'd1, 3, 1'b0, 1'b1);
      step("n_wash_start_ign", 1'b1, 1'b0, 1'b1, 3'd2, 5);
      run_phase("n_wash", 3'd2, 4, 1'b0, 1'b1);
      run_phase("n_drain", 3'd3, 2, 1'b0, 1'b1);
      run_phase("n_rinse", 3'd4, 4, 1'b0, 1'b1);
      run_phase("n_spin", 3'd5, 3, 1'b0, 1'b1);
      step("n_done", 1'b0, 1'b1, 1'b1, 3'd6, 0);
      step("n_idle", 1'b0, 1'b1, 1'b1, 3'd0, 0);
      step("n_idle2", 1'b0, 1'b0, 1'b1, 3'd0, 0);

      // start with door open is ignored
      step("door_open_start", 1'b1, 1'b0, 1'b0, 3'd0, 0);
      step("door_open_idle", 1'b0, 1'b0, 1'b0, 3'd0, 0);
      step("door_open_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);

      // abort in WASH at rem=3; abort held in DRAIN is ignored
      step("ab_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      run_phase("ab_fill", 3'd1, 3, 1'b0, 1'b1);
      step("ab_wash", 1'b0, 1'b0, 1'b1, 3'd2, 5);
      step("ab_wash", 1'b0, 1'b0, 1'b1, 3'd2, 4);
      step("ab_wash_abort", 1'b0, 1'b1, 1'b1, 3'd2, 3);
      run_phase("ab_drain", 3'd3, 2, 1'b1, 1'b1);
      step("ab_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("ab_idle2", 1'b0, 1'b0, 1'b1, 3'd0, 0);

      // abort on the terminal FILL cycle wins over the phase end
      step("abl_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      step("abl_fill", 1'b0, 1'b0, 1'b1, 3'd1, 3);
      step("abl_fill", 1'b0, 1'b0, 1'b1, 3'd1, 2);
      step("abl_fill_abort", 1'b0, 1'b1, 1'b1, 3'd1, 1);
      run_phase("abl_drain", 3'd3, 2, 1'b0, 1'b1);
      step("abl_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);

      // abort in SPIN goes straight to IDLE
      normal_to_rinse("abs");
      step("abs_spin_abort", 1'b0, 1'b1, 1'b1, 3'd5, 3);
      step("abs_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("abs_idle2", 1'b0, 1'b0, 1'b1, 3'd0, 0);

`ifndef WASH_DOOR_PAUSE_EN
      // door opening acts as abort; ignored in DRAIN
      step("dr_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      run_phase("dr_fill", 3'd1, 3, 1'b0, 1'b1);
      run_phase("dr_wash", 3'd2, 5, 1'b0, 1'b1);
      run_phase("dr_drain_door_ign", 3'd3, 2, 1'b0, 1'b0);
      step("dr_rinse", 1'b0, 1'b0, 1'b1, 3'd4, 4);
      step("dr_rinse_door", 1'b0, 1'b0, 1'b0, 3'd4, 3);
      run_phase("dr_drain", 3'd3, 2, 1'b0, 1'b1);
      step("dr_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("dr_idle2", 1'b0, 1'b0, 1'b1, 3'd0, 0);
`else
      // door opens in WASH at rem=4, closes 10 cycles later, cycle completes
      step("pz_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      run_phase("pz_fill", 3'd1, 3, 1'b0, 1'b1);
      step("pz_wash", 1'b0, 1'b0, 1'b1, 3'd2, 5);
      step("pz_wash_door", 1'b0, 1'b0, 1'b0, 3'd2, 4);
      for (int i = 0; i < 9; i++) step("pz_pause", 1'b0, 1'b0, 1'b0, 3'd7, 4);
      step("pz_pause_close", 1'b0, 1'b0, 1'b1, 3'd7, 4);
      run_phase("pz_wash_resume", 3'd2, 4, 1'b0, 1'b1);
      run_phase("pz_drain", 3'd3, 2, 1'b0, 1'b1);
      run_phase("pz_rinse", 3'd4, 4, 1'b0, 1'b1);
      run_phase("pz_spin", 3'd5, 3, 1'b0, 1'b1);
      step("pz_done", 1'b0, 1'b0, 1'b1, 3'd6, 0);
      step("pz_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      // abort while paused returns to IDLE
      step("pa_start", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      step("pa_fill", 1'b0, 1'b0, 1'b1, 3'd1, 3);
      step("pa_fill_door", 1'b0, 1'b0, 1'b0, 3'd1, 2);
      step("pa_pause_abort", 1'b0, 1'b1, 1'b0, 3'd7, 2);
      step("pa_idle", 1'b0, 1'b0, 1'b1, 3'd0, 0);
`endif

      // asynchronous reset during SPIN
      normal_to_rinse("rs");
      step("rs_spin", 1'b0, 1'b0, 1'b1, 3'd5, 3);
      step("rs_spin", 1'b0, 1'b0, 1'b1, 3'd5, 2);
      #3 rst = 1'b0;
      #1 check_now("reset_async", 3'd0, 0, 7'b0);
      @(posedge clk);
      #1 check_now("reset_held", 3'd0, 0, 7'b0);
      rst = 1'b1;
      @(posedge clk);
      step("rs_no_resume", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("rs_no_resume", 1'b0, 1'b0, 1'b1, 3'd0, 0);
      step("rs_restart", 1'b1, 1'b0, 1'b1, 3'd0, 0);
      step("rs_fill", 1'b0, 1'b0, 1'b1, 3'd1, 3);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain_scoreboard: got %0d entries left, want 0", sb.size());
      end
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
